lsu_store_buffer: RTL and testbench
===================================

// Module: lsu_store_buffer
// PURPOSE
// Parametrised store buffer between LSU store path and DCCM write port. Decouples store issue
// from DCCM write availability. Drains stores in program order, one per cycle.
// Optionally coalesces same-word stores. Supplies byte-granular store-to-load forwarding so
// the LSU can merge buffered bytes over DCCM read data.
// PARAMETERS
// XLEN      32  data/address width; XLEN/8 byte lanes
// SB_DEPTH  4   entries; power of 2, >= 2
// COALESCE  1   1: merge a store into youngest entry on word-address match; 0: never merge
// PORTS
// clk          in   1          clock, all state on rising edge
// rst          in   1          asynchronous, active-high reset
// st_valid     in   1          store request valid
// st_ready     out  1          store accepted when st_valid & st_ready
// st_addr      in   XLEN       store address; bits [1:0] ignored (word-aligned entry)
// st_data      in   XLEN       store data, already lane-aligned
// st_be        in   XLEN/8     byte enables
// ld_addr      in   XLEN       load lookup address; bits [1:0] ignored
// ld_fwd_data  out  XLEN       forwarded bytes (lanes with ld_fwd_be=0 are 0)
// ld_fwd_be    out  XLEN/8     lanes covered by buffered stores
// dccm_waddr   out  XLEN       head entry word address, {addr[XLEN-1:2],2'b00}
// dccm_wdata   out  XLEN       head entry data
// dccm_wbe     out  XLEN/8     head entry byte enables
// dccm_wen     out  1          head entry valid
// dccm_wready  in   1          DCCM accepts write this cycle
// sb_count     out  $clog2(SB_DEPTH+1)  occupied entries
// sb_full      out  1          sb_count == SB_DEPTH
// sb_empty     out  1          sb_count == 0 (fence/drain complete)
// BEHAVIOUR
// - Reset: all entries invalid; head/tail pointers 0; count 0.
// - Reset output values: st_ready=1, dccm_wen=0, dccm_waddr/wdata/wbe=0, ld_fwd_be=0,
//   ld_fwd_data=0, sb_empty=1, sb_full=0.
// - Reset asserted mid-operation: pending stores are discarded immediately (async).
// - Circular FIFO: tail advances on push, head on pop.
//   Pointers wrap modulo SB_DEPTH.
// - Pop: dccm_wen = ~sb_empty (combinational from state). Head retires on dccm_wen & dccm_wready.
// - Push: st_valid & st_ready. Entry is written at tail and becomes visible next cycle.
// - Coalesce (COALESCE=1):
//   - Condition: sb_count >= 2 and word addr == youngest entry addr.
//   - Merge: youngest.data lane i <= st_data lane i where st_be[i]; youngest.be |= st_be.
//   - No count change. Never merges into the head entry (count==1), so head is stable while presented.
// - st_ready = ~sb_full | coalesce_hit. A full buffer does not admit a same-cycle pop bypass.
// - Simultaneous push+pop: count unchanged; both pointers advance.
// - Simultaneous coalesce+pop: pop only changes count.
// - Forwarding (combinational, 0-cycle), per byte lane i:
//   - Selects the youngest valid entry with matching word addr and be[i]=1.
//   - The head retiring this cycle still forwards.
//   - The store being pushed this cycle does not forward.
// - Partial coverage is legal: LSU merges ld_fwd_data where ld_fwd_be over DCCM rdata.
// - Load-after-store ordering across the buffer is exact; no entry is ever dropped or reordered.
// TESTING
// 1. 4 stores, dccm_wready=0 -> sb_full=1, st_ready=0 after 4th; 5th (distinct addr) held until a pop.
// 2. Drain with dccm_wready=1 -> DCCM writes 1/cycle in push order with exact addr/data/be;
//    sb_empty=1 after last.
// 3. COALESCE=0:
//    - Store 0x100 be=0011 data=0x11223344, then 0x100 be=1100 data=0xAABBCCDD.
//    - ld_addr=0x102 -> ld_fwd_be=1111, ld_fwd_data=0xAABB3344.
// 4. COALESCE=1, count=2, youngest 0x200 be=0001 data=0x000000EE:
//    - Store 0x200 be=0010 data=0x0000DD00 -> count stays 2; drained entry be=0011, data=0x0000DDEE.
// 5. count=2, push+pop same cycle -> count stays 2.
//    count=4, pop only -> next cycle st_ready=1, sb_full=0.
// 6. count=3 mid-drain, assert rst -> same cycle dccm_wen=0, sb_empty=1, ld_fwd_be=0;
//    after release, no stale writes.

Source files
------------

// File: rtl/lsu_store_buffer.sv
// Store buffer between the LSU store path and the DCCM write port.
// In-order circular FIFO of word-aligned entries, optional coalescing into the
// youngest non-head entry, and byte-granular store-to-load forwarding.
module lsu_store_buffer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned COALESCE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [XLEN-1:0]               st_addr,
    input  logic [XLEN-1:0]               st_data,
    input  logic [XLEN/8-1:0]             st_be,
    input  logic [XLEN-1:0]               ld_addr,
    output logic [XLEN-1:0]               ld_fwd_data,
    output logic [XLEN/8-1:0]             ld_fwd_be,
    output logic [XLEN-1:0]               dccm_waddr,
    output logic [XLEN-1:0]               dccm_wdata,
    output logic [XLEN/8-1:0]             dccm_wbe,
    output logic                          dccm_wen,
    input  logic                          dccm_wready,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic                          sb_full,
    output logic                          sb_empty
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned AW = XLEN - 2;
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = $clog2(SB_DEPTH + 1);

    // Entry storage: word address, lane-aligned data, byte enables, valid
    logic [AW-1:0]       r_addr [SB_DEPTH];
    logic [XLEN-1:0]     r_data [SB_DEPTH];
    logic [NB-1:0]       r_be   [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_valid;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic [PW-1:0] w_young;
    logic          w_hit;
    logic          w_push;
    logic          w_alloc;
    logic          w_pop;
    logic [PW-1:0] w_idx;
    logic          w_unused;

    // Byte-offset bits of both addresses are architecturally ignored
    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

    // Coalescing only targets the youngest entry, and never the head (count >= 2)
    assign w_young = r_tail - PW'(1);
    assign w_hit   = (COALESCE != 0) && (r_count >= CW'(2)) &&
                     (st_addr[XLEN-1:2] == r_addr[w_young]);

    assign sb_count = r_count;
    assign sb_full  = (r_count == CW'(SB_DEPTH));
    assign sb_empty = (r_count == '0);

    // A full buffer only accepts a merging store; no same-cycle pop bypass
    assign st_ready = ~sb_full | w_hit;
    assign w_push   = st_valid & st_ready;
    assign w_alloc  = w_push & ~w_hit;

    // Head entry is presented whenever the buffer holds anything
    assign dccm_wen   = ~sb_empty;
    assign w_pop      = dccm_wen & dccm_wready;
    assign dccm_waddr = dccm_wen ? {r_addr[r_head], 2'b00} : '0;
    assign dccm_wdata = dccm_wen ? r_data[r_head] : '0;
    assign dccm_wbe   = dccm_wen ? r_be[r_head] : '0;

    // FIFO state: allocate at tail, merge into youngest, retire head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int k = 0; k < SB_DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
                r_be[k]   <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_addr[r_tail]  <= st_addr[XLEN-1:2];
                r_data[r_tail]  <= st_data;
                r_be[r_tail]    <= st_be;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end else if (w_push) begin
                for (int i = 0; i < NB; i++) begin
                    if (st_be[i]) begin
                        r_data[w_young][8*i +: 8] <= st_data[8*i +: 8];
                    end
                end
                r_be[w_young] <= r_be[w_young] | st_be;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding: walk oldest to youngest so the youngest matching byte wins
    always_comb begin
        ld_fwd_data = '0;
        ld_fwd_be   = '0;
        w_idx       = r_head;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr[XLEN-1:2])) begin
                for (int i = 0; i < NB; i++) begin
                    if (r_be[w_idx][i]) begin
                        ld_fwd_be[i]            = 1'b1;
                        ld_fwd_data[8*i +: 8]   = r_data[w_idx][8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: a coalescing instance checked against a
// queue-based model every cycle, plus a non-coalescing instance.
`timescale 1ns/1ps
module tb_lsu_store_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Coalescing instance
    logic        st_valid, st_ready, dccm_wen, dccm_wready, sb_full, sb_empty;
    logic [31:0] st_addr, st_data, ld_addr, ld_fwd_data, dccm_waddr, dccm_wdata;
    logic [3:0]  st_be, ld_fwd_be, dccm_wbe;
    logic [2:0]  sb_count;

    // Non-coalescing instance
    logic        n_valid, n_ready, n_wen, n_wready, n_full, n_empty;
    logic [31:0] n_addr, n_data, n_ld, n_fwd_data, n_waddr, n_wdata;
    logic [3:0]  n_be, n_fwd_be, n_wbe;
    logic [2:0]  n_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    ent_t q[$];

    lsu_store_buffer #(.XLEN(32), .SB_DEPTH(DEPTH), .COALESCE(1)) u_dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_be(ld_fwd_be),
        .dccm_waddr(dccm_waddr), .dccm_wdata(dccm_wdata), .dccm_wbe(dccm_wbe),
        .dccm_wen(dccm_wen), .dccm_wready(dccm_wready),
        .sb_count(sb_count), .sb_full(sb_full), .sb_empty(sb_empty)
    );

    lsu_store_buffer #(.XLEN(32), .SB_DEPTH(DEPTH), .COALESCE(0)) u_dut_nc (
        .clk(clk), .rst(rst),
        .st_valid(n_valid), .st_ready(n_ready), .st_addr(n_addr), .st_data(n_data), .st_be(n_be),
        .ld_addr(n_ld), .ld_fwd_data(n_fwd_data), .ld_fwd_be(n_fwd_be),
        .dccm_waddr(n_waddr), .dccm_wdata(n_wdata), .dccm_wbe(n_wbe),
        .dccm_wen(n_wen), .dccm_wready(n_wready),
        .sb_count(n_count), .sb_full(n_full), .sb_empty(n_empty)
    );

    // Scoreboard: model state is compared, then updated, on every falling edge
    always @(negedge clk) begin : mon
        ent_t        e;
        logic [3:0]  fbe;
        logic [31:0] fdat;
        logic        hit, rdy;
        int          n0, last;
        if (dccm_wen && dccm_wready) n_writes++;
        if (rst) begin
            q.delete();
            n_checks++;
            if ({dccm_wen, sb_count, ld_fwd_be} !== 8'h00) begin
                n_fail++;
                $display("FAIL mon_reset: wen/count/fwd_be got %b required 0", {dccm_wen, sb_count, ld_fwd_be});
            end
        end else begin
            n0   = q.size();
            fbe  = '0;
            fdat = '0;
            foreach (q[j]) begin
                if (q[j].addr[31:2] == ld_addr[31:2]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (q[j].be[i]) begin
                            fbe[i]          = 1'b1;
                            fdat[8*i +: 8]  = q[j].data[8*i +: 8];
                        end
                    end
                end
            end
            hit = (n0 >= 2) && (q[n0-1].addr[31:2] == st_addr[31:2]);
            rdy = (n0 < DEPTH) || hit;
            n_checks++;
            if ({sb_count, sb_full, sb_empty, dccm_wen, st_ready} !==
                {3'(n0), n0 == DEPTH, n0 == 0, n0 != 0, rdy}) begin
                n_fail++;
                $display("FAIL mon_status: count/full/empty/wen/ready got %b required %b",
                         {sb_count, sb_full, sb_empty, dccm_wen, st_ready},
                         {3'(n0), n0 == DEPTH, n0 == 0, n0 != 0, rdy});
            end
            n_checks++;
            if ({ld_fwd_be, ld_fwd_data} !== {fbe, fdat}) begin
                n_fail++;
                $display("FAIL mon_fwd: ld_addr %h got be=%b data=%h required be=%b data=%h",
                         ld_addr, ld_fwd_be, ld_fwd_data, fbe, fdat);
            end
            if (st_valid && rdy) begin
                if (hit) begin
                    last = n0 - 1;
                    e    = q[last];
                    for (int i = 0; i < 4; i++) begin
                        if (st_be[i]) e.data[8*i +: 8] = st_data[8*i +: 8];
                    end
                    e.be    = e.be | st_be;
                    q[last] = e;
                end else begin
                    e.addr = {st_addr[31:2], 2'b00};
                    e.data = st_data;
                    e.be   = st_be;
                    q.push_back(e);
                end
            end
            if (dccm_wready && n0 != 0) begin
                e = q.pop_front();
                n_checks++;
                if ({dccm_wen, dccm_waddr, dccm_wdata, dccm_wbe} !== {1'b1, e.addr, e.data, e.be}) begin
                    n_fail++;
                    $display("FAIL mon_dccm: got wen=%b addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                             dccm_wen, dccm_waddr, dccm_wdata, dccm_wbe, e.addr, e.data, e.be);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({st_ready, dccm_wen, sb_empty, sb_full, sb_count} !== 7'b1010_000) begin
            n_fail++;
            $display("FAIL reset_status: ready/wen/empty/full/count got %b required 1010000",
                     {st_ready, dccm_wen, sb_empty, sb_full, sb_count});
        end
        n_checks++;
        if ({dccm_waddr, dccm_wdata, dccm_wbe, ld_fwd_be, ld_fwd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: waddr=%h wdata=%h wbe=%b fbe=%b fdata=%h required all 0",
                     dccm_waddr, dccm_wdata, dccm_wbe, ld_fwd_be, ld_fwd_data);
        end
        n_checks++;
        if ({n_ready, n_wen, n_empty, n_full, n_count} !== 7'b1010_000) begin
            n_fail++;
            $display("FAIL reset_nc_status: got %b required 1010000", {n_ready, n_wen, n_empty, n_full, n_count});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [3:0] bes [4];
        bes = '{4'hF, 4'h3, 4'hC, 4'h1};
        dccm_wready = 1'b0;
        ld_addr     = 32'h22;
        for (int k = 0; k < 4; k++) begin
            put(32'h10 + 32'(k) * 32'h10, 32'hA0A0_0000 + 32'(k), bes[k]);
            step();
        end
        put(32'h50, 32'h5555_5555, 4'hF);
        #1;
        n_checks++;
        if ({sb_full, st_ready, sb_count} !== {1'b1, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL fill_full: full/ready/count got %b required 104", {sb_full, st_ready, sb_count});
        end
        step();
        dccm_wready = 1'b1;
        #1;
        n_checks++;
        if (st_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_no_bypass: st_ready got %b required 0", st_ready);
        end
        step();
        dccm_wready = 1'b0;
        #1;
        n_checks++;
        if ({sb_full, st_ready, sb_count} !== {1'b0, 1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL fill_after_pop: full/ready/count got %b required 013", {sb_full, st_ready, sb_count});
        end
        step();
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (sb_count !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_fifth: count got %0d required 4", sb_count);
        end
    endtask

    task automatic test_drain();
        int cyc;
        int w0;
        w0          = n_writes;
        cyc         = 0;
        dccm_wready = 1'b1;
        while (!sb_empty && cyc < 20) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL drain_cycles: got %0d required 4", cyc);
        end
        n_checks++;
        if (n_writes - w0 != 4) begin
            n_fail++;
            $display("FAIL drain_writes: got %0d required 4", n_writes - w0);
        end
        n_checks++;
        if ({sb_empty, dccm_wen} !== 2'b10) begin
            n_fail++;
            $display("FAIL drain_empty: empty/wen got %b required 10", {sb_empty, dccm_wen});
        end
        dccm_wready = 1'b0;
    endtask

    task automatic test_nocoalesce();
        logic [31:0] xd [3];
        logic [3:0]  xb [3];
        xd = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0000_00FF};
        xb = '{4'b0011, 4'b1100, 4'b0001};
        n_wready = 1'b0;
        n_ld     = 32'h102;
        for (int k = 0; k < 2; k++) begin
            n_valid = 1'b1; n_addr = 32'h100; n_data = xd[k]; n_be = xb[k];
            step();
        end
        n_valid = 1'b0;
        #1;
        n_checks++;
        if ({n_fwd_be, n_fwd_data} !== {4'hF, 32'hAABB_3344}) begin
            n_fail++;
            $display("FAIL nc_fwd: be=%b data=%h required be=1111 data=aabb3344", n_fwd_be, n_fwd_data);
        end
        n_valid = 1'b1; n_addr = 32'h100; n_data = xd[2]; n_be = xb[2];
        step();
        n_valid = 1'b0;
        #1;
        n_checks++;
        if ({n_count, n_fwd_be, n_fwd_data} !== {3'd3, 4'hF, 32'hAABB_33FF}) begin
            n_fail++;
            $display("FAIL nc_no_merge: count=%0d be=%b data=%h required 3 1111 aabb33ff", n_count, n_fwd_be, n_fwd_data);
        end
        n_ld = 32'h104;
        #1;
        n_checks++;
        if (n_fwd_be !== 4'h0) begin
            n_fail++;
            $display("FAIL nc_fwd_miss: be got %b required 0000", n_fwd_be);
        end
        n_wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({n_wen, n_waddr, n_wdata, n_wbe} !== {1'b1, 32'h100, xd[k], xb[k]}) begin
                n_fail++;
                $display("FAIL nc_drain_%0d: wen=%b addr=%h data=%h be=%b required 1 00000100 %h %b",
                         k, n_wen, n_waddr, n_wdata, n_wbe, xd[k], xb[k]);
            end
            step();
        end
        n_checks++;
        if ({n_empty, n_wen} !== 2'b10) begin
            n_fail++;
            $display("FAIL nc_drain_empty: empty/wen got %b required 10", {n_empty, n_wen});
        end
        n_wready = 1'b0;
    endtask

    task automatic test_coalesce();
        dccm_wready = 1'b0;
        put(32'h1F0, 32'hCAFE_BABE, 4'hF);      step();
        put(32'h200, 32'h0000_00EE, 4'b0001);   step();
        put(32'h200, 32'h0000_DD00, 4'b0010);   step();
        st_valid = 1'b0;
        ld_addr  = 32'h200;
        #1;
        n_checks++;
        if ({sb_count, ld_fwd_be, ld_fwd_data} !== {3'd2, 4'b0011, 32'h0000_DDEE}) begin
            n_fail++;
            $display("FAIL coal_merge: count=%0d be=%b data=%h required 2 0011 0000ddee", sb_count, ld_fwd_be, ld_fwd_data);
        end
        dccm_wready = 1'b1;
        step();
        n_checks++;
        if ({dccm_waddr, dccm_wdata, dccm_wbe} !== {32'h200, 32'h0000_DDEE, 4'b0011}) begin
            n_fail++;
            $display("FAIL coal_drain: addr=%h data=%h be=%b required 00000200 0000ddee 0011", dccm_waddr, dccm_wdata, dccm_wbe);
        end
        step();
        dccm_wready = 1'b0;
        put(32'h400, 32'h0000_00AA, 4'b0001);   step();
        put(32'h400, 32'h0000_BB00, 4'b0010);   step();
        n_checks++;
        if (sb_count !== 3'd2) begin
            n_fail++;
            $display("FAIL coal_head_guard: count got %0d required 2", sb_count);
        end
        put(32'h400, 32'h00CC_0000, 4'b0100);   step();
        st_valid = 1'b0;
        ld_addr  = 32'h403;
        #1;
        n_checks++;
        if ({sb_count, ld_fwd_be, ld_fwd_data} !== {3'd2, 4'b0111, 32'h00CC_BBAA}) begin
            n_fail++;
            $display("FAIL coal_young: count=%0d be=%b data=%h required 2 0111 00ccbbaa", sb_count, ld_fwd_be, ld_fwd_data);
        end
    endtask

    task automatic test_back_to_back();
        put(32'h500, 32'h1234_5678, 4'hF);
        dccm_wready = 1'b1;
        step();
        n_checks++;
        if (sb_count !== 3'd2) begin
            n_fail++;
            $display("FAIL b2b_push_pop: count got %0d required 2", sb_count);
        end
        put(32'h500, 32'h9A00_0000, 4'b1000);
        step();
        st_valid = 1'b0;
        ld_addr  = 32'h500;
        #1;
        n_checks++;
        if ({sb_count, ld_fwd_be, ld_fwd_data} !== {3'd1, 4'hF, 32'h9A34_5678}) begin
            n_fail++;
            $display("FAIL b2b_coal_pop: count=%0d be=%b data=%h required 1 1111 9a345678", sb_count, ld_fwd_be, ld_fwd_data);
        end
        step();
        n_checks++;
        if (sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_empty: sb_empty got %b required 1", sb_empty);
        end
        dccm_wready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w0;
        dccm_wready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(32'h600 + 32'(k) * 32'h10, 32'h6000_0000 + 32'(k), 4'hF);
            step();
        end
        put(32'h630, 32'h7700_0000, 4'b1000);
        #1;
        n_checks++;
        if ({sb_full, st_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_merge_ready: full/ready got %b required 11", {sb_full, st_ready});
        end
        step();
        st_valid    = 1'b0;
        dccm_wready = 1'b1;
        step();
        ld_addr = 32'h620;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dccm_wen, sb_empty, ld_fwd_be, sb_count, dccm_waddr} !== {1'b0, 1'b1, 4'h0, 3'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid: wen=%b empty=%b fbe=%b count=%0d waddr=%h required 0 1 0000 0 0",
                     dccm_wen, sb_empty, ld_fwd_be, sb_count, dccm_waddr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        w0  = n_writes;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({dccm_wen, sb_empty} !== 2'b01) begin
                n_fail++;
                $display("FAIL rst_stale_%0d: wen/empty got %b required 01", k, {dccm_wen, sb_empty});
            end
        end
        n_checks++;
        if (n_writes != w0) begin
            n_fail++;
            $display("FAIL rst_no_writes: got %0d writes required 0", n_writes - w0);
        end
        dccm_wready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        st_valid    = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        st_be       = '0;
        ld_addr     = '0;
        dccm_wready = 1'b0;
        n_valid     = 1'b0;
        n_addr      = '0;
        n_data      = '0;
        n_be        = '0;
        n_ld        = '0;
        n_wready    = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_nocoalesce();
        test_coalesce();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
